debug_bus_master: RTL and testbench

DEBUG_BUS_MASTER -- requirements
Module: debug_bus_master

---
 rtl/debug_bus_master.sv | 150 +++++++++++++++
 tb/tb_debug_bus_master.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_bus_master.sv
// rtl/debug_bus_master.sv - single-outstanding debug bus master with per-phase timeout
module debug_bus_master #(
  parameter logic [7:0]  IDLE_ADDR = 8'hFF,
  parameter int unsigned TIMEOUT   = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [7:0]  req_addr,
  input  logic [63:0] req_data,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic [1:0]  resp_err,
  output logic [7:0]  bus_addr,
  output logic        bus_start,
  inout  wire  [63:0] bus_data,
  input  logic        bus_available,
  input  logic        bus_accepted
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_ACC = 3'd2,
    ST_WAIT_AVL = 3'd3,
    ST_GUARD    = 3'd4,
    ST_RESP     = 3'd5
  } state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [1:0]  ERR_OK       = 2'd0;
  localparam logic [1:0]  ERR_ACC_TMO  = 2'd1;
  localparam logic [1:0]  ERR_AVL_TMO  = 2'd2;

  state_t      state_q, state_d;
  logic [7:0]  addr_q, addr_d;
  logic [63:0] cmd_q, cmd_d;
  logic [63:0] resp_data_q, resp_data_d;
  logic [1:0]  resp_err_q, resp_err_d;
  logic [15:0] cnt_q, cnt_d;

  logic acc;
  logic avl;
  logic phase_expired;
  logic in_txn;

  // Responder strobes count only when solidly high; floating or unknown is "not yet".
  assign acc = (bus_accepted === 1'b1);
  assign avl = (bus_available === 1'b1);

  assign phase_expired = (cnt_q == TIMEOUT_LAST);

  // Address is owned by the transaction from START until GUARD completes.
  assign in_txn = (state_q == ST_START) || (state_q == ST_WAIT_ACC) ||
                  (state_q == ST_WAIT_AVL) || (state_q == ST_GUARD);

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign bus_start  = (state_q == ST_START);
  assign bus_addr   = in_txn ? addr_q : IDLE_ADDR;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;

  // The command word is only on the bus during START; the responder owns it otherwise.
  assign bus_data = (state_q == ST_START) ? cmd_q : {64{1'bz}};

  // Next-state, request capture and response capture.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    cmd_d       = cmd_q;
    resp_data_d = resp_data_q;
    resp_err_d  = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          cmd_d   = req_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        state_d = ST_WAIT_ACC;
      end
      ST_WAIT_ACC: begin
        if (acc && avl) begin
          // Zero-wait responder: data is already valid alongside acceptance.
          resp_data_d = bus_data;
          resp_err_d  = ERR_OK;
          state_d     = ST_GUARD;
        end else if (acc) begin
          state_d = ST_WAIT_AVL;
        end else if (phase_expired) begin
          resp_err_d = ERR_ACC_TMO;
          state_d    = ST_RESP;
        end
      end
      ST_WAIT_AVL: begin
        if (avl) begin
          resp_data_d = bus_data;
          resp_err_d  = ERR_OK;
          state_d     = ST_GUARD;
        end else if (phase_expired) begin
          resp_err_d = ERR_AVL_TMO;
          state_d    = ST_RESP;
        end
      end
      ST_GUARD: begin
        state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Phase counter restarts on every state change and sticks at its maximum.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = 16'd0;
    end else if (cnt_q != 16'hFFFF) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= IDLE_ADDR;
      cmd_q       <= 64'd0;
      resp_data_q <= 64'd0;
      resp_err_q  <= ERR_OK;
      cnt_q       <= 16'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      resp_data_q <= resp_data_d;
      resp_err_q  <= resp_err_d;
      cnt_q       <= cnt_d;
    end
  end

endmodule

// File: tb/tb_debug_bus_master.sv
// tb/tb_debug_bus_master.sv - scoreboard bench for debug_bus_master with a responder at address 2
module tb_debug_bus_master;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [7:0]  req_addr = 8'd0;
  logic [63:0] req_data = 64'd0;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic [1:0]  resp_err;
  logic [7:0]  bus_addr;
  logic        bus_start;
  wire  [63:0] bus_data;
  logic        bus_available = 1'b0;
  logic        bus_accepted = 1'b0;

  logic        rsp_drive = 1'b0;
  logic        probe_en = 1'b0;
  logic [63:0] rsp_val = 64'd0;
  logic [63:0] rsp_cmd = 64'd0;
  int          stage = 0;
  bit          stall = 1'b0;

  assign bus_data = rsp_drive ? rsp_val : (probe_en ? 64'h0 : {64{1'bz}});

  always #5 clk = ~clk;

  debug_bus_master #(
    .IDLE_ADDR(8'hFF),
    .TIMEOUT(TMO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_data(req_data),
    .resp_valid(resp_valid),
    .resp_data(resp_data),
    .resp_err(resp_err),
    .bus_addr(bus_addr),
    .bus_start(bus_start),
    .bus_data(bus_data),
    .bus_available(bus_available),
    .bus_accepted(bus_accepted)
  );

  typedef struct packed {logic [63:0] data; logic [1:0] err;} resp_t;
  typedef struct packed {logic [7:0] addr; logic [63:0] data;} start_t;

  resp_t  exp_q[$];
  start_t start_q[$];
  resp_t  mon_r;
  start_t mon_s;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int start_cnt = 0;
  int resp_cnt = 0;
  int last_start_cyc = 0;
  int last_resp_cyc = 0;
  int prev_resp_cyc = 0;
  logic [63:0] last_exp_data = 64'd0;

  function automatic logic [63:0] rsp_value(input logic [63:0] cmd);
    if (cmd[63:56] == 8'h5A) return 64'd123;
    return 64'hFFFF_FFFF_FFFF_FFAB;
  endfunction

  // Responder at address 2: accept one cycle after start, data-valid one cycle later.
  always @(negedge clk) begin
    if (!rst) begin
      stage = 0;
      bus_accepted = 1'b0;
      bus_available = 1'b0;
      rsp_drive = 1'b0;
    end else begin
      case (stage)
        0: if (bus_start === 1'b1 && bus_addr == 8'd2) begin
             rsp_cmd = bus_data;
             stage = 1;
           end
        1: begin
             bus_accepted = 1'b1;
             stage = 2;
           end
        2: begin
             bus_accepted = 1'b0;
             if (stall) begin
               stage = 0;
             end else begin
               bus_available = 1'b1;
               rsp_val = rsp_value(rsp_cmd);
               rsp_drive = 1'b1;
               stage = 3;
             end
           end
        default: begin
             bus_available = 1'b0;
             rsp_drive = 1'b0;
             stage = 0;
           end
      endcase
    end
  end

  // Monitor: checks every start strobe and every response against the scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (bus_start === 1'b1) begin
      start_cnt++;
      last_start_cyc = cyc;
      vectors++;
      if (start_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_start cyc=%0d addr=%h data=%h", cyc, bus_addr, bus_data);
      end else begin
        mon_s = start_q.pop_front();
        if (bus_addr !== mon_s.addr || bus_data !== mon_s.data) begin
          miscompares++;
          $display("FAIL start_bus got addr=%h data=%h want addr=%h data=%h",
                   bus_addr, bus_data, mon_s.addr, mon_s.data);
        end
      end
    end
    if (resp_valid === 1'b1) begin
      resp_cnt++;
      prev_resp_cyc = last_resp_cyc;
      last_resp_cyc = cyc;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_resp cyc=%0d data=%h err=%0d", cyc, resp_data, resp_err);
      end else begin
        mon_r = exp_q.pop_front();
        if (resp_data !== mon_r.data || resp_err !== mon_r.err) begin
          miscompares++;
          $display("FAIL resp got data=%h err=%0d want data=%h err=%0d",
                   resp_data, resp_err, mon_r.data, mon_r.err);
        end
      end
    end
  end

  task automatic do_req(input logic [7:0] a, input logic [63:0] d, input bit hold, output int xcyc);
    bit rdy;
    bit done;
    done = 1'b0;
    req_valid = 1'b1;
    req_addr = a;
    req_data = d;
    start_q.push_back(start_t'({a, d}));
    for (int i = 0; i < 100 && !done; i++) begin
      rdy = req_ready;
      @(posedge clk);
      #1;
      if (rdy) done = 1'b1;
    end
    vectors++;
    if (!done) begin
      miscompares++;
      $display("FAIL req_transfer got ready_seen=0 want 1 addr=%h", a);
    end
    xcyc = cyc;
    if (!hold) req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int target, input string tag);
    for (int i = 0; i < 200 && resp_cnt < target; i++) begin
      @(posedge clk);
      #1;
    end
    vectors++;
    if (resp_cnt < target) begin
      miscompares++;
      $display("FAIL %s_resp_wait got=%0d want=%0d", tag, resp_cnt, target);
    end
  endtask

  task automatic test_reset;
    #2 rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 || bus_start !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ctrl got ready=%b rv=%b start=%b want 1 0 0", req_ready, resp_valid, bus_start);
    end
    vectors++;
    if (resp_data !== 64'd0 || resp_err !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_resp got data=%h err=%0d want 0 0", resp_data, resp_err);
    end
    vectors++;
    if (bus_addr !== 8'hFF) begin
      miscompares++;
      $display("FAIL reset_addr got=%h want=ff", bus_addr);
    end
    probe_en = 1'b1;
    #1;
    vectors++;
    if (bus_data !== 64'h0) begin
      miscompares++;
      $display("FAIL reset_bus_release got=%h want=0", bus_data);
    end
    probe_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read;
    int x;
    int s0;
    int r0;
    s0 = start_cnt;
    r0 = resp_cnt;
    last_exp_data = 64'hFFFF_FFFF_FFFF_FFAB;
    exp_q.push_back(resp_t'({last_exp_data, 2'd0}));
    do_req(8'd2, 64'h0000_0000_0001_2301, 1'b0, x);
    wait_resp(r0 + 1, "read");
    vectors++;
    if (last_resp_cyc - x != 5) begin
      miscompares++;
      $display("FAIL read_latency got=%0d want=5", last_resp_cyc - x);
    end
    vectors++;
    if (start_cnt - s0 != 1) begin
      miscompares++;
      $display("FAIL read_start_pulses got=%0d want=1", start_cnt - s0);
    end
    probe_en = 1'b1;
    #1;
    vectors++;
    if (bus_data !== 64'h0) begin
      miscompares++;
      $display("FAIL idle_bus_release got=%h want=0", bus_data);
    end
    probe_en = 1'b0;
  endtask

  task automatic test_write;
    int x;
    int r0;
    r0 = resp_cnt;
    last_exp_data = 64'd123;
    exp_q.push_back(resp_t'({last_exp_data, 2'd0}));
    do_req(8'd2, 64'h5A00_0000_0004_5600, 1'b0, x);
    wait_resp(r0 + 1, "write");
    vectors++;
    if (last_resp_cyc - x != 5) begin
      miscompares++;
      $display("FAIL write_latency got=%0d want=5", last_resp_cyc - x);
    end
  endtask

  task automatic test_missing;
    int x;
    int r0;
    r0 = resp_cnt;
    exp_q.push_back(resp_t'({last_exp_data, 2'd1}));
    do_req(8'd7, 64'h0000_0000_0000_0777, 1'b0, x);
    repeat (5) @(posedge clk);
    #1;
    vectors++;
    if (bus_addr !== 8'd7) begin
      miscompares++;
      $display("FAIL missing_busy_addr got=%h want=07", bus_addr);
    end
    wait_resp(r0 + 1, "missing");
    vectors++;
    if (last_resp_cyc - last_start_cyc - 1 != TMO) begin
      miscompares++;
      $display("FAIL missing_wait got=%0d want=%0d", last_resp_cyc - last_start_cyc - 1, TMO);
    end
    vectors++;
    if (bus_addr !== 8'hFF) begin
      miscompares++;
      $display("FAIL missing_idle_addr got=%h want=ff", bus_addr);
    end
  endtask

  task automatic test_stalled;
    int x;
    int r0;
    r0 = resp_cnt;
    stall = 1'b1;
    exp_q.push_back(resp_t'({last_exp_data, 2'd2}));
    do_req(8'd2, 64'h0000_0000_0001_2301, 1'b0, x);
    wait_resp(r0 + 1, "stalled");
    vectors++;
    if (last_resp_cyc - last_start_cyc - 1 != TMO + 1) begin
      miscompares++;
      $display("FAIL stalled_wait got=%0d want=%0d", last_resp_cyc - last_start_cyc - 1, TMO + 1);
    end
    stall = 1'b0;
  endtask

  task automatic test_back_to_back;
    int x1;
    int x2;
    int r0;
    r0 = resp_cnt;
    exp_q.push_back(resp_t'({64'hFFFF_FFFF_FFFF_FFAB, 2'd0}));
    exp_q.push_back(resp_t'({64'd123, 2'd0}));
    last_exp_data = 64'd123;
    do_req(8'd2, 64'h0000_0000_0001_2301, 1'b1, x1);
    do_req(8'd2, 64'h5A00_0000_0004_5600, 1'b0, x2);
    wait_resp(r0 + 2, "b2b");
    vectors++;
    if ((x2 + 1) - prev_resp_cyc < 2) begin
      miscompares++;
      $display("FAIL b2b_gap got=%0d want>=2", (x2 + 1) - prev_resp_cyc);
    end
    vectors++;
    if (prev_resp_cyc - x1 != 5 || last_resp_cyc - x2 != 5) begin
      miscompares++;
      $display("FAIL b2b_latency got=%0d,%0d want=5,5", prev_resp_cyc - x1, last_resp_cyc - x2);
    end
  endtask

  task automatic test_reset_mid;
    int x;
    int r0;
    bit seen;
    r0 = resp_cnt;
    seen = 1'b0;
    do_req(8'd2, 64'h0000_0000_0001_2301, 1'b0, x);
    for (int i = 0; i < 20 && !seen; i++) begin
      if (stage == 2) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL rstmid_reach_wait_avl got=0 want=1");
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (bus_start !== 1'b0 || bus_addr !== 8'hFF || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_outputs got start=%b addr=%h ready=%b want 0 ff 1", bus_start, bus_addr, req_ready);
    end
    probe_en = 1'b1;
    #1;
    vectors++;
    if (bus_data !== 64'h0) begin
      miscompares++;
      $display("FAIL rstmid_bus_release got=%h want=0", bus_data);
    end
    probe_en = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    vectors++;
    if (resp_cnt != r0 || resp_data !== 64'd0) begin
      miscompares++;
      $display("FAIL rstmid_no_resp got cnt=%0d data=%h want cnt=%0d data=0", resp_cnt, resp_data, r0);
    end
    @(posedge clk);
    #1;
    last_exp_data = 64'hFFFF_FFFF_FFFF_FFAB;
    exp_q.push_back(resp_t'({last_exp_data, 2'd0}));
    do_req(8'd2, 64'h0000_0000_0001_2301, 1'b0, x);
    wait_resp(r0 + 1, "rstmid_after");
    vectors++;
    if (last_resp_cyc - x != 5) begin
      miscompares++;
      $display("FAIL rstmid_after_latency got=%0d want=5", last_resp_cyc - x);
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_missing();
    test_stalled();
    test_back_to_back();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (exp_q.size() != 0 || start_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain got resp=%0d start=%0d want 0 0", exp_q.size(), start_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
